// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single write port of an async FIFO among
// NUM_REQ write-domain producers, granting bursts of up to MAX_BURST words.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [ID_W-1:0]  gnt_next;
  logic [ID_W-1:0]  search_start;
  logic [ID_W-1:0]  search_win;
  logic             search_hit;
  logic             xfer;
  logic             last_beat;
  logic             release_gnt;

  // Handshake: producer i's word moves in any cycle where req_valid[i] and
  // req_ready[i] are both high; a raised valid must hold with stable data
  // until that cycle. Only the granted producer can ever see ready.

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  assign gnt_next     = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
  assign search_start = (state == GRANT) ? gnt_next : rr_ptr;

  // Descending scan so the nearest set bit at or after search_start wins.
  always_comb begin
    search_hit = 1'b0;
    search_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(search_start, k)]) begin
        search_hit = 1'b1;
        search_win = wrap_idx(search_start, k);
      end
    end
  end

  assign xfer        = (state == GRANT) & req_valid[gnt] & ~fifo_full;
  assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_gnt = (state == GRANT) & ((xfer & last_beat) | ~req_valid[gnt]);

  // The full flag reaches the write strobe combinationally so a full FIFO
  // is never offered a word.
  always_comb begin
    req_ready      = '0;
    req_ready[gnt] = xfer;
    fifo_wen       = xfer;
    fifo_wdata     = xfer ? req_data[int'(gnt) * DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = gnt;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (search_hit) begin
            gnt      <= search_win;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            rr_ptr <= gnt_next;
            if (search_hit) begin
              gnt      <= search_win;
              beat_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus a randomized
// end-to-end run against a FIFO model and a round-robin reference model.
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic               wclk;
  logic               wrst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wen;
  logic [DW-1:0]      fifo_wdata;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  int              cnt [NREQ];
  logic [NREQ-1:0] acc;

  logic [DW-1:0] src_q [NREQ][$];
  logic [DW-1:0] exp_q [NREQ][$];
  logic [DW-1:0] fifo_q [$];

  fifo_write_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_W(IDW)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] word(input int i, input int k);
    return DW'(i * 64 + k);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  // driver tasks
  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word(i, cnt[i]);
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic f);
    @(negedge wclk);
    req_valid = v;
    fifo_full = f;
    drive_data();
    #2;
    acc = req_ready;
    for (int i = 0; i < NREQ; i++) if (acc[i]) cnt[i]++;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n    = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    acc       = '0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    drive_data();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    outs = {grant_valid, grant_id, fifo_wen, fifo_wdata, req_ready};
    checks++;
    if (outs !== 16'h0) begin
      errors++;
      $display("FAIL reset_por: outputs=%h required 0000", outs);
    end
    do_reset();
    repeat (3) step(4'b1111, 1'b0);
    checks++;
    if (grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant: grant_valid=%b required 1", grant_valid);
    end
    #1 wrst_n = 1'b0;
    #1;
    outs = {grant_valid, grant_id, fifo_wen, fifo_wdata, req_ready};
    checks++;
    if (outs !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required 0000", outs);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    acc       = '0;
    req_valid = 4'b0110;
    drive_data();
    #2;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after_release: grant_valid=%b required 0", grant_valid);
    end
    step(4'b0110, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd1 || fifo_wen !== 1'b1 ||
        fifo_wdata !== word(1, 0) || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_first_grant: gv=%b id=%0d wen=%b data=%h rdy=%b required 1 1 1 %h 0010",
               grant_valid, grant_id, fifo_wen, fifo_wdata, req_ready, word(1, 0));
    end
  endtask

  task automatic test_single_regrant();
    int  nw;
    logic exp_gv, exp_wen;
    nw = 0;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      step((cnt[0] < 6) ? 4'b0001 : 4'b0000, 1'b0);
      exp_gv  = (t >= 1 && t <= 7);
      exp_wen = (t >= 1 && t <= 6);
      if (fifo_wen === 1'b1) nw++;
      checks++;
      if (grant_valid !== exp_gv || fifo_wen !== exp_wen) begin
        errors++;
        $display("FAIL single_ctrl t=%0d: gv=%b wen=%b required %b %b",
                 t, grant_valid, fifo_wen, exp_gv, exp_wen);
      end
      if (exp_wen) begin
        checks++;
        if (fifo_wdata !== word(0, t - 1) || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
          errors++;
          $display("FAIL single_data t=%0d: data=%h rdy=%b id=%0d required %h 0001 0",
                   t, fifo_wdata, req_ready, grant_id, word(0, t - 1));
        end
      end
    end
    checks++;
    if (nw != 6) begin
      errors++;
      $display("FAIL single_count: writes=%0d required 6", nw);
    end
  endtask

  task automatic test_saturated();
    int k, eid;
    do_reset();
    step(4'b1111, 1'b0);
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_idle: grant_valid=%b required 0", grant_valid);
    end
    for (int t = 1; t < 18; t++) begin
      step(4'b1111, 1'b0);
      k   = t - 1;
      eid = (k / MB) % NREQ;
      checks++;
      if (grant_id !== IDW'(eid) || fifo_wen !== 1'b1 ||
          fifo_wdata !== word(eid, (k / (MB * NREQ)) * MB + k % MB) ||
          req_ready !== NREQ'(1 << eid)) begin
        errors++;
        $display("FAIL sat t=%0d: id=%0d wen=%b data=%h rdy=%b required %0d 1 %h %b",
                 t, grant_id, fifo_wen, fifo_wdata, req_ready, eid,
                 word(eid, (k / (MB * NREQ)) * MB + k % MB), NREQ'(1 << eid));
      end
    end
  endtask

  task automatic test_full_stall();
    int   k, nw;
    logic full, exp_wen;
    k  = 0;
    nw = 0;
    do_reset();
    step(4'b0100, 1'b0);
    for (int t = 1; t < 9; t++) begin
      full = (t >= 3 && t <= 5);
      step(4'b0100, full);
      exp_wen = !full;
      if (fifo_wen === 1'b1) nw++;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd2 || fifo_wen !== exp_wen ||
          req_ready !== (exp_wen ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL stall_ctrl t=%0d: gv=%b id=%0d wen=%b rdy=%b required 1 2 %b",
                 t, grant_valid, grant_id, fifo_wen, req_ready, exp_wen);
      end
      if (exp_wen) begin
        checks++;
        if (fifo_wdata !== word(2, k)) begin
          errors++;
          $display("FAIL stall_data t=%0d: data=%h required %h", t, fifo_wdata, word(2, k));
        end
        k++;
      end
    end
    checks++;
    if (nw != 5) begin
      errors++;
      $display("FAIL stall_count: writes=%0d required 5", nw);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    checks++;
    if (grant_id !== 2'd1 || fifo_wen !== 1'b1 || fifo_wdata !== word(1, 0)) begin
      errors++;
      $display("FAIL early_p1: id=%0d wen=%b data=%h required 1 1 %h",
               grant_id, fifo_wen, fifo_wdata, word(1, 0));
    end
    step(4'b1000, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd1 || fifo_wen !== 1'b0) begin
      errors++;
      $display("FAIL early_drop: gv=%b id=%0d wen=%b required 1 1 0", grant_valid, grant_id, fifo_wen);
    end
    step(4'b1000, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd3 || fifo_wen !== 1'b1 ||
        fifo_wdata !== word(3, 0) || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL early_p3: gv=%b id=%0d wen=%b data=%h rdy=%b required 1 3 1 %h 1000",
               grant_valid, grant_id, fifo_wen, fifo_wdata, req_ready, word(3, 0));
    end
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    checks++;
    if (grant_id !== 2'd0 || fifo_wen !== 1'b1 || fifo_wdata !== word(0, 0)) begin
      errors++;
      $display("FAIL early_wrap: id=%0d wen=%b data=%h required 0 1 %h",
               grant_id, fifo_wen, fifo_wdata, word(0, 0));
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] vld, v;
    logic            full_now, p_wen, m_busy, done;
    logic [DW-1:0]   p_data, w, e;
    logic [NREQ-1:0] p_ready;
    int              m_owner, m_beats, m_ptr, win, id, n;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      n = $urandom_range(15, 30);
      for (int j = 0; j < n; j++) begin
        w = {2'(i), 6'($urandom_range(0, 63))};
        src_q[i].push_back(w);
        exp_q[i].push_back(w);
      end
    end
    fifo_q.delete();
    vld     = '0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge wclk);
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        w  = fifo_q.pop_front();
        id = int'(w[DW-1:DW-2]);
        checks++;
        if (exp_q[id].size() == 0) begin
          errors++;
          $display("FAIL rand_extra: producer %0d word=%h required none", id, w);
        end else begin
          e = exp_q[id].pop_front();
          if (w !== e) begin
            errors++;
            $display("FAIL rand_order: producer %0d word=%h required %h", id, w, e);
          end
        end
      end
      full_now = (fifo_q.size() >= DEPTH);
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && src_q[i].size() > 0 && $urandom_range(0, 3) != 0) vld[i] = 1'b1;
        req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
      req_valid = vld;
      fifo_full = full_now;
      #2;
      v       = vld;
      p_wen   = m_busy && v[m_owner] && !full_now;
      p_ready = p_wen ? NREQ'(1 << m_owner) : '0;
      p_data  = p_wen ? src_q[m_owner][0] : '0;
      checks++;
      if (grant_valid !== m_busy || grant_id !== IDW'(m_owner)) begin
        errors++;
        $display("FAIL rand_grant cyc=%0d: gv=%b id=%0d required %b %0d",
                 cyc, grant_valid, grant_id, m_busy, m_owner);
      end
      checks++;
      if (fifo_wen !== p_wen || req_ready !== p_ready || fifo_wdata !== p_data) begin
        errors++;
        $display("FAIL rand_xfer cyc=%0d: wen=%b rdy=%b data=%h required %b %b %h",
                 cyc, fifo_wen, req_ready, fifo_wdata, p_wen, p_ready, p_data);
      end
      checks++;
      if (fifo_wen === 1'b1 && full_now) begin
        errors++;
        $display("FAIL rand_overflow cyc=%0d: wen=1 while full required 0", cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] === 1'b1) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          vld[i] = 1'b0;
        end
      end
      if (fifo_wen === 1'b1 && !full_now) fifo_q.push_back(fifo_wdata);
      if (!m_busy) begin
        win = pick(v, m_ptr);
        if (win >= 0) begin
          m_busy  = 1'b1;
          m_owner = win;
          m_beats = 0;
        end
      end else begin
        if (p_wen) m_beats++;
        if ((p_wen && m_beats == MB) || !v[m_owner]) begin
          m_ptr = (m_owner + 1) % NREQ;
          win   = pick(v, m_ptr);
          if (win >= 0) begin
            m_owner = win;
            m_beats = 0;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
      done = (vld == '0) && (fifo_q.size() == 0);
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_timeout: traffic not drained within cycle budget");
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL rand_missing: producer %0d has %0d words undelivered required 0",
                 i, exp_q[i].size());
      end
    end
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    acc       = '0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    drive_data();
    #2;
    test_reset();
    test_single_regrant();
    test_saturated();
    test_full_stall();
    test_early_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
